// File: rtl/icache_refill_ctrl_if.sv
// rtl/icache_refill_ctrl_if.sv - miss, MPU, memory-bus and fill signal bundle for the I$ refill controller
interface icache_refill_ctrl_if #(
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = $clog2(LINE_WORDS)
);
    logic              miss_valid_i;
    logic [31:0]       miss_addr_i;
    logic              miss_ready_o;
    logic [31:0]       mpu_query_addr_o;
    logic              mpu_exec_allow_i;
    logic              bus_req_o;
    logic [31:0]       bus_addr_o;
    logic              bus_gnt_i;
    logic              bus_rvalid_i;
    logic [31:0]       bus_rdata_i;
    logic              bus_err_i;
    logic              flush_i;
    logic              fill_we_o;
    logic [IDX_W-1:0]  fill_idx_o;
    logic [31:0]       fill_data_o;
    logic              fill_done_o;
    logic              fault_o;
    logic [31:0]       fault_cause_o;
    logic [31:0]       fault_tval_o;
    logic              busy_o;

    modport slave (
        input  miss_valid_i, miss_addr_i, mpu_exec_allow_i, bus_gnt_i,
               bus_rvalid_i, bus_rdata_i, bus_err_i, flush_i,
        output miss_ready_o, mpu_query_addr_o, bus_req_o, bus_addr_o,
               fill_we_o, fill_idx_o, fill_data_o, fill_done_o,
               fault_o, fault_cause_o, fault_tval_o, busy_o
    );

    modport master (
        output miss_valid_i, miss_addr_i, mpu_exec_allow_i, bus_gnt_i,
               bus_rvalid_i, bus_rdata_i, bus_err_i, flush_i,
        input  miss_ready_o, mpu_query_addr_o, bus_req_o, bus_addr_o,
               fill_we_o, fill_idx_o, fill_data_o, fill_done_o,
               fault_o, fault_cause_o, fault_tval_o, busy_o
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - I$ line refill FSM: MPU execute check, bus line read, beat fill, fault/flush handling
module icache_refill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic               clk,
    input  logic               rst,
    icache_refill_ctrl_if.slave io
);
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_REQ, S_BEAT, S_DRAIN} state_t;

    localparam int          OFF_W     = IDX_W + 2;
    localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);
    localparam logic [31:0] CAUSE_IFETCH = 32'h1;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_cnt;
    logic [31:0]      r_miss_addr;
    logic [31:0]      r_line_addr;
    logic [31:0]      r_cause;
    logic [31:0]      r_tval;

    logic w_last;
    logic w_ready;
    logic w_accept;
    logic w_grant;
    logic w_beat;
    logic w_fill_we;
    logic w_done;
    logic w_fault;

    assign w_last = (r_cnt == IDX_W'(LINE_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_CHECK;
            end
            S_CHECK: begin
                if (io.flush_i)               w_next = S_IDLE;
                else if (io.mpu_exec_allow_i) w_next = S_REQ;
                else                          w_next = S_IDLE;
            end
            S_REQ: begin
                // A grant in the flush cycle commits the bus to a full line, so it must be drained.
                if (io.bus_gnt_i)    w_next = io.flush_i ? S_DRAIN : S_BEAT;
                else if (io.flush_i) w_next = S_IDLE;
            end
            S_BEAT: begin
                if (io.bus_rvalid_i) begin
                    if (w_last)                          w_next = S_IDLE;
                    else if (io.flush_i || io.bus_err_i) w_next = S_DRAIN;
                end else if (io.flush_i) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (io.bus_rvalid_i && w_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready   = 1'b0;
        w_accept  = 1'b0;
        w_grant   = 1'b0;
        w_beat    = 1'b0;
        w_fill_we = 1'b0;
        w_done    = 1'b0;
        w_fault   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready  = ~io.flush_i & ~rst;
                w_accept = io.miss_valid_i & w_ready;
            end
            S_CHECK: begin
                w_fault = ~io.flush_i & ~io.mpu_exec_allow_i & ~rst;
            end
            S_REQ: begin
                w_grant = io.bus_gnt_i;
            end
            S_BEAT: begin
                w_beat = io.bus_rvalid_i;
                if (io.bus_rvalid_i && !io.flush_i && !rst) begin
                    if (io.bus_err_i) begin
                        w_fault = 1'b1;
                    end else begin
                        w_fill_we = 1'b1;
                        w_done    = w_last;
                    end
                end
            end
            S_DRAIN: begin
                w_beat = io.bus_rvalid_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_miss_addr <= '0;
            r_line_addr <= '0;
            r_cause     <= '0;
            r_tval      <= '0;
        end else begin
            if (w_accept) begin
                r_miss_addr <= io.miss_addr_i;
                r_line_addr <= io.miss_addr_i & LINE_MASK;
            end
            if (w_grant)     r_cnt <= '0;
            else if (w_beat) r_cnt <= r_cnt + IDX_W'(1);
            if (w_fault) begin
                r_cause <= CAUSE_IFETCH;
                r_tval  <= r_miss_addr;
            end
        end
    end

    // Cause/tval are valid during the fault pulse itself and then held in registers.
    assign io.miss_ready_o     = w_ready;
    assign io.mpu_query_addr_o = r_line_addr;
    assign io.bus_addr_o       = r_line_addr;
    assign io.bus_req_o        = (r_state == S_REQ) & ~rst;
    assign io.fill_we_o        = w_fill_we;
    assign io.fill_idx_o       = r_cnt;
    assign io.fill_data_o      = w_fill_we ? io.bus_rdata_i : 32'h0;
    assign io.fill_done_o      = w_done;
    assign io.fault_o          = w_fault;
    assign io.fault_cause_o    = w_fault ? CAUSE_IFETCH : r_cause;
    assign io.fault_tval_o     = w_fault ? r_miss_addr : r_tval;
    assign io.busy_o           = (r_state != S_IDLE) & ~rst;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - self-checking bench for icache_refill_ctrl with a transaction-level model
module tb_icache_refill_ctrl;
    localparam int LW = 4;
    localparam int IW = $clog2(LW);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    icache_refill_ctrl_if #(.LINE_WORDS(LW)) bus_if ();
    icache_refill_ctrl #(.LINE_WORDS(LW)) dut (.clk(clk), .rst(rst), .io(bus_if));

    int          mon_fill_idx[$];
    logic [31:0] mon_fill_data[$];
    int          mon_done;
    int          mon_fault;
    int          mon_req;
    logic [31:0] mon_fault_tval;
    logic [31:0] mon_fault_cause;
    logic [31:0] exp_cause_hold = 32'h0;
    logic [31:0] exp_tval_hold  = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus_if.fill_we_o) begin
            mon_fill_idx.push_back(int'(bus_if.fill_idx_o));
            mon_fill_data.push_back(bus_if.fill_data_o);
        end
        if (bus_if.fill_done_o) begin
            mon_done++;
            chk("done_with_last_fill", {31'b0, bus_if.fill_we_o && (int'(bus_if.fill_idx_o) == LW - 1)}, 32'h1);
        end
        if (bus_if.fault_o) begin
            mon_fault++;
            mon_fault_tval  = bus_if.fault_tval_o;
            mon_fault_cause = bus_if.fault_cause_o;
            chk("fault_excl_fill", {31'b0, bus_if.fill_we_o}, 32'h0);
        end
        if (bus_if.bus_req_o) mon_req++;
    end

    task automatic idle_inputs();
        bus_if.miss_valid_i     = 1'b0;
        bus_if.mpu_exec_allow_i = 1'b0;
        bus_if.bus_gnt_i        = 1'b0;
        bus_if.bus_rvalid_i     = 1'b0;
        bus_if.bus_err_i        = 1'b0;
        bus_if.flush_i          = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // fl_mode: 0 none, 1 flush in REQ before grant, 2 flush on beat fl_b, 3 flush with grant
    task automatic run_miss(input logic [31:0] addr, input bit allow, input int gdly,
                            input int err_b, input int fl_mode, input int fl_b, input bit gaps);
        logic [31:0] line;
        logic [31:0] d [LW];
        int          n_fill;
        bit          e_fault;
        bit          e_done;
        line = addr & ~(32'(LW * 4) - 32'd1);
        mon_fill_idx.delete();
        mon_fill_data.delete();
        mon_done = 0; mon_fault = 0; mon_req = 0;

        bus_if.miss_valid_i = 1'b1;
        bus_if.miss_addr_i  = addr;
        @(negedge clk) chk("miss_ready", {31'b0, bus_if.miss_ready_o}, 32'h1);
        step();
        bus_if.miss_valid_i     = 1'b0;
        bus_if.miss_addr_i      = $urandom;
        bus_if.mpu_exec_allow_i = allow;
        bus_if.bus_rvalid_i     = 1'b1;
        @(negedge clk) chk("mpu_query_addr", bus_if.mpu_query_addr_o, line);
        step();
        bus_if.mpu_exec_allow_i = 1'b0;
        bus_if.bus_rvalid_i     = 1'b0;
        if (allow) begin
            for (int k = 0; k < gdly; k++) begin
                bus_if.bus_rvalid_i = 1'($urandom % 2);
                step();
            end
            bus_if.bus_rvalid_i = 1'b0;
            bus_if.bus_gnt_i    = (fl_mode != 1);
            bus_if.flush_i      = (fl_mode == 1 || fl_mode == 3);
            @(negedge clk) chk("bus_addr", bus_if.bus_addr_o, line);
            step();
            bus_if.bus_gnt_i = 1'b0;
            bus_if.flush_i   = 1'b0;
            if (fl_mode == 1) begin
                @(negedge clk) chk("flush_req_idle", {31'b0, bus_if.busy_o}, 32'h0);
                bus_if.bus_rvalid_i = 1'b1;
                step();
                step();
                bus_if.bus_rvalid_i = 1'b0;
            end else begin
                for (int i = 0; i < LW; i++) begin
                    if (gaps && ($urandom % 2 == 1)) step();
                    d[i] = $urandom;
                    bus_if.bus_rvalid_i = 1'b1;
                    bus_if.bus_rdata_i  = d[i];
                    bus_if.bus_err_i    = (i == err_b);
                    bus_if.flush_i      = (fl_mode == 2 && i == fl_b);
                    step();
                    bus_if.bus_rvalid_i = 1'b0;
                    bus_if.bus_err_i    = 1'b0;
                    bus_if.flush_i      = 1'b0;
                end
            end
        end
        @(negedge clk) chk("busy_after", {31'b0, bus_if.busy_o}, 32'h0);

        n_fill = LW;
        if (err_b >= 0 && err_b < n_fill) n_fill = err_b;
        if (fl_mode == 2 && fl_b < n_fill) n_fill = fl_b;
        if (!allow || fl_mode == 1 || fl_mode == 3) n_fill = 0;
        e_fault = !allow || (fl_mode == 0 && err_b >= 0) || (fl_mode == 2 && err_b >= 0 && err_b < fl_b);
        e_done  = allow && fl_mode == 0 && err_b < 0;

        chk("fill_count", 32'(mon_fill_idx.size()), 32'(n_fill));
        for (int i = 0; i < n_fill && i < mon_fill_idx.size(); i++) begin
            chk("fill_idx", 32'(mon_fill_idx[i]), 32'(i));
            chk("fill_data", mon_fill_data[i], d[i]);
        end
        chk("done_count", 32'(mon_done), 32'(e_done));
        chk("fault_count", 32'(mon_fault), 32'(e_fault));
        chk("req_cycles", 32'(mon_req), allow ? 32'(gdly + 1) : 32'h0);
        if (e_fault) begin
            chk("fault_cause", mon_fault_cause, 32'h1);
            chk("fault_tval", mon_fault_tval, addr);
            exp_cause_hold = 32'h1;
            exp_tval_hold  = addr;
        end
        chk("cause_hold", bus_if.fault_cause_o, exp_cause_hold);
        chk("tval_hold", bus_if.fault_tval_o, exp_tval_hold);
        step();
    endtask

    initial begin
        idle_inputs();
        bus_if.miss_addr_i = 32'h0;
        bus_if.bus_rdata_i = 32'h0;
        step();
        step();
        @(negedge clk) begin
            chk("rst_busy", {31'b0, bus_if.busy_o}, 32'h0);
            chk("rst_ready", {31'b0, bus_if.miss_ready_o}, 32'h0);
            chk("rst_bus_addr", bus_if.bus_addr_o, 32'h0);
        end
        step();
        rst = 1'b0;
        @(negedge clk) begin
            chk("idle_ready", {31'b0, bus_if.miss_ready_o}, 32'h1);
            chk("idle_cause", bus_if.fault_cause_o, 32'h0);
            chk("idle_tval", bus_if.fault_tval_o, 32'h0);
        end
        step();

        run_miss(32'h0000_1234, 1'b1, 2, -1, 0, 0, 1'b0);
        chk("line_1230", bus_if.bus_addr_o, 32'h0000_1230);
        run_miss(32'h8000_0008, 1'b0, 0, -1, 0, 0, 1'b0);
        run_miss(32'h0000_2040, 1'b1, 1, 1, 0, 0, 1'b0);
        run_miss(32'h0000_3000, 1'b1, 1, -1, 1, 0, 1'b0);
        run_miss(32'h0000_4010, 1'b1, 0, -1, 2, 2, 1'b0);
        run_miss(32'h0000_5020, 1'b1, 0, 2, 2, 2, 1'b0);
        run_miss(32'h0000_6030, 1'b1, 1, 3, 3, 0, 1'b0);
        run_miss(32'h0000_7004, 1'b1, 0, 3, 0, 0, 1'b1);

        // Reset in the middle of a refill.
        bus_if.miss_valid_i = 1'b1;
        bus_if.miss_addr_i  = 32'hA000_0044;
        step();
        bus_if.miss_valid_i     = 1'b0;
        bus_if.mpu_exec_allow_i = 1'b1;
        step();
        bus_if.mpu_exec_allow_i = 1'b0;
        bus_if.bus_gnt_i        = 1'b1;
        step();
        bus_if.bus_gnt_i    = 1'b0;
        bus_if.bus_rvalid_i = 1'b1;
        step();
        step();
        rst = 1'b1;
        @(negedge clk) chk("rst_mid_fill_we", {31'b0, bus_if.fill_we_o}, 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk) begin
            chk("rst_mid_busy", {31'b0, bus_if.busy_o}, 32'h0);
            chk("rst_mid_fill_we2", {31'b0, bus_if.fill_we_o}, 32'h0);
            chk("rst_mid_fault", {31'b0, bus_if.fault_o}, 32'h0);
            chk("rst_mid_cause", bus_if.fault_cause_o, 32'h0);
            chk("rst_mid_tval", bus_if.fault_tval_o, 32'h0);
            chk("rst_mid_addr", bus_if.bus_addr_o, 32'h0);
            chk("rst_mid_req", {31'b0, bus_if.bus_req_o}, 32'h0);
        end
        step();
        bus_if.bus_rvalid_i = 1'b0;
        exp_cause_hold = 32'h0;
        exp_tval_hold  = 32'h0;
        run_miss(32'h0000_8888, 1'b1, 0, -1, 0, 0, 1'b0);

        // Flush held in IDLE blocks acceptance; then flush in CHECK aborts silently.
        mon_fault = 0; mon_req = 0;
        bus_if.flush_i      = 1'b1;
        bus_if.miss_valid_i = 1'b1;
        bus_if.miss_addr_i  = 32'h0000_9990;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk) begin
                chk("flush_idle_ready", {31'b0, bus_if.miss_ready_o}, 32'h0);
                chk("flush_idle_busy", {31'b0, bus_if.busy_o}, 32'h0);
            end
            step();
        end
        bus_if.flush_i = 1'b0;
        @(negedge clk) chk("flush_drop_ready", {31'b0, bus_if.miss_ready_o}, 32'h1);
        step();
        bus_if.miss_valid_i = 1'b0;
        bus_if.flush_i      = 1'b1;
        @(negedge clk) chk("check_busy", {31'b0, bus_if.busy_o}, 32'h1);
        step();
        bus_if.flush_i = 1'b0;
        @(negedge clk) begin
            chk("flush_check_idle", {31'b0, bus_if.busy_o}, 32'h0);
            chk("flush_check_nofault", 32'(mon_fault), 32'h0);
            chk("flush_check_noreq", 32'(mon_req), 32'h0);
        end
        step();

        for (int t = 0; t < 40; t++) begin
            int modes [5] = '{0, 0, 1, 2, 3};
            run_miss($urandom, ($urandom % 4) != 0, int'($urandom % 3),
                     ($urandom % 3 == 0) ? int'($urandom % LW) : -1,
                     modes[$urandom % 5], int'($urandom % LW), 1'($urandom % 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 Parameters SHALL be:
  LINE_WORDS, 4, words per I$ line; power of two, >= 2
  IDX_W, $clog2(LINE_WORDS), beat-index width
REQ-002 Clocking and reset SHALL be one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be:
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  miss_valid_i  in  1  I$ reports miss
  miss_addr_i  in  32  physical fetch address of miss
  miss_ready_o  out  1  miss accepted when valid&ready
  mpu_query_addr_o  out  32  line-aligned address for MPU execute check
  mpu_exec_allow_i  in  1  combinational MPU execute permission for mpu_query_addr_o
  bus_req_o  out  1  line read request to memory
  bus_addr_o  out  32  line-aligned request address
  bus_gnt_i  in  1  request accepted
  bus_rvalid_i  in  1  read beat valid
  bus_rdata_i  in  32  read beat data
  bus_err_i  in  1  beat error, qualified by bus_rvalid_i
  flush_i  in  1  abort current refill (fence.i / redirect)
  fill_we_o  out  1  write one word into I$ data array
  fill_idx_o  out  IDX_W  word index within line
  fill_data_o  out  32  word data
  fill_done_o  out  1  one-cycle pulse: line complete, set valid bit
  fault_o  out  1  one-cycle fetch fault pulse to trap unit
  fault_cause_o  out  32  fault code
  fault_tval_o  out  32  offending address
  busy_o  out  1  state != IDLE

Function
REQ-004 FSM states SHALL be IDLE, CHECK, REQ, BEAT, DRAIN.
REQ-005 IDLE: miss_ready_o = ~flush_i; on handshake latch miss_addr_i (tval) and line address (low $clog2(LINE_WORDS)+2 bits zeroed), go CHECK; miss_ready_o SHALL be 0 in all other states.
REQ-006 CHECK (exactly one cycle): mpu_query_addr_o = latched line address; allow=1 -> REQ; allow=0 -> fault_o pulse, cause 32'h1, tval = latched miss address, -> IDLE; no bus_req_o ever issued for a denied line.
REQ-007 REQ: bus_req_o=1, bus_addr_o = line address, held stable until bus_gnt_i; grant -> BEAT with beat counter = 0.
REQ-008 BEAT: each bus_rvalid_i with bus_err_i=0 drives fill_we_o=1, fill_idx_o=counter, fill_data_o=bus_rdata_i same cycle (zero-latency pass-through), counter increments.
REQ-009 Beat with counter = LINE_WORDS-1 and no error SHALL pulse fill_done_o in the same cycle as its fill_we_o and return to IDLE; counter wraps to 0.
REQ-010 Beat with bus_err_i=1: no fill_we_o, fault_o pulse, cause 32'h1, tval = latched miss address; if it was the last beat -> IDLE, else -> DRAIN; fill_done_o never pulses for that line.
REQ-011 DRAIN: consume remaining beats (counter continues) with fill_we_o=0, fill_done_o=0, no further faults; after beat LINE_WORDS-1 -> IDLE.
REQ-012 flush_i in CHECK or REQ SHALL return to IDLE next cycle with no fault and no fill; a REQ already granted in the same cycle as flush_i counts as granted -> DRAIN.
REQ-013 flush_i in BEAT SHALL suppress fill_we_o and fill_done_o in that cycle and go DRAIN (or IDLE if that cycle carries the last beat); flush_i in DRAIN or IDLE has no effect beyond REQ-005.
REQ-014 Simultaneous flush_i and error beat: flush wins, no fault_o.
REQ-015 bus_rvalid_i in IDLE, CHECK or REQ SHALL be ignored.
REQ-016 fault_o, fill_we_o, fill_done_o SHALL never assert together with fault_o except never: fault_o and fill_we_o are mutually exclusive every cycle.
REQ-017 fault_cause_o and fault_tval_o SHALL hold their last value when fault_o=0; mpu_query_addr_o and bus_addr_o SHALL show the latched line address in all states.

Reset
REQ-018 rst=1 at any clock edge SHALL force IDLE, counter 0, latched addresses 0, all outputs 0 (fault_cause_o=0, fault_tval_o=0), mid-refill included; beats arriving after reset are ignored.

Verification
REQ-019 Miss 0x0000_1234, allow=1, gnt after 2 cycles, 4 beats D0..D3 -> bus_addr_o=0x0000_1230, fill_idx 0..3 with D0..D3, fill_done_o on 4th beat, busy_o low next cycle.
REQ-020 Miss 0x8000_0008, allow=0 -> fault_o one cycle in CHECK, cause 0x1, tval 0x8000_0008, bus_req_o never asserted.
REQ-021 Error on beat 1 of 4 -> fill_we_o only for beat 0, fault_o with tval = miss address, beats 2..3 drained silently, no fill_done_o.
REQ-022 flush_i during REQ before gnt -> IDLE next cycle, no fault, no fill; flush_i on beat 2 -> beats 2..3 not written, no fill_done_o, then IDLE.
REQ-023 rst asserted after beat 1 -> all outputs 0 next cycle; remaining beats ignored; new miss accepted normally afterwards.
REQ-024 flush_i high with miss_valid_i in IDLE -> miss_ready_o=0, miss accepted first cycle flush_i drops.
